// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: one-hot op codes, FSM states,
// default operand width and a one-hot test helper. The upstream button
// controller imports the same op constants.
package alu_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_MOD3 = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True when exactly one bit of the op code is set.
  function automatic logic is_onehot4(input logic [3:0] code);
    return (code != 4'b0000) && ((code & (code - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per cycle, DATA_W
// cycles after start. product is the running sum including the current
// step, so on last_step it is the complete 2*DATA_W product.
module alu_mul_seq #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   product,
  output logic                  last_step
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] partial;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    count;
  logic                active;

  // Select the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    partial = {(2*DATA_W){1'b0}};
    if (mplier[0]) begin
      partial = mcand;
    end else begin
      partial = {(2*DATA_W){1'b0}};
    end
  end

  assign product   = acc + partial;
  assign last_step = active && (count == CNT_W'(DATA_W - 1));

  // Load operands on start, then accumulate and shift once per step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= {(2*DATA_W){1'b0}};
      acc    <= {(2*DATA_W){1'b0}};
      mplier <= {DATA_W{1'b0}};
      count  <= {CNT_W{1'b0}};
      active <= 1'b0;
    end else if (start) begin
      mcand  <= {{DATA_W{1'b0}}, a};
      acc    <= {(2*DATA_W){1'b0}};
      mplier <= b;
      count  <= {CNT_W{1'b0}};
      active <= 1'b1;
    end else if (active) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CNT_W'(1);
      active <= !last_step;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Sequential ALU executing ADD, SUB, MUL (shift-add) and MOD3 (repeated
// subtraction) on operands captured by load strobes. An op starts when the
// one-hot control changes or an operand is loaded while idle.
// Optional build macro: ALU_SUB_SAT_EN makes SUB clamp to zero when B > A;
// without it SUB wraps in 2*DATA_W two's complement.
module alu_exec
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            control,
  input  logic [DATA_W-1:0]     operand_in,
  input  logic                  load_a,
  input  logic                  load_b,
  output logic [2*DATA_W-1:0]   result,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);

  localparam logic [DATA_W-1:0] THREE = DATA_W'(3);

  state_t              state, state_next;
  logic [3:0]          ctrl_q;
  logic [3:0]          op;
  logic [DATA_W-1:0]   reg_a, reg_b, a_next, b_next;
  logic [DATA_W-1:0]   mod_work;
  logic                trigger, illegal, fin;
  logic [2*DATA_W-1:0] fin_val;
  logic [2*DATA_W-1:0] mul_product;
  logic                mul_last;
  logic                mul_start;

  assign mul_start = trigger && (control == OP_MUL);

  alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start     (mul_start),
    .a         (a_next),
    .b         (b_next),
    .product   (mul_product),
    .last_step (mul_last)
  );

  // Operand capture; a load in the trigger cycle feeds the new op directly.
  always_comb begin
    a_next = reg_a;
    b_next = reg_b;
    if (state != ST_CALC) begin
      if (load_a) a_next = operand_in; else a_next = reg_a;
      if (load_b) b_next = operand_in; else b_next = reg_b;
    end else begin
      a_next = reg_a;
      b_next = reg_b;
    end
  end

  // Trigger and illegal-code detection while no operation is in progress.
  always_comb begin
    trigger = 1'b0;
    illegal = 1'b0;
    if (state == ST_IDLE) begin
      trigger = is_onehot4(control) && ((control != ctrl_q) || load_a || load_b);
    end else begin
      trigger = 1'b0;
    end
    if (state != ST_CALC) begin
      illegal = (control != OP_NONE) && !is_onehot4(control);
    end else begin
      illegal = 1'b0;
    end
  end

  // Per-op completion test and final value for the current step.
  always_comb begin
    fin     = 1'b0;
    fin_val = result;
    case (op)
      OP_ADD: begin
        fin     = 1'b1;
        fin_val = {{DATA_W{1'b0}}, reg_a} + {{DATA_W{1'b0}}, reg_b};
      end
      OP_SUB: begin
        fin = 1'b1;
`ifdef ALU_SUB_SAT_EN
        if (reg_b > reg_a) begin
          fin_val = {(2*DATA_W){1'b0}};
        end else begin
          fin_val = {{DATA_W{1'b0}}, reg_a - reg_b};
        end
`else
        fin_val = {{DATA_W{1'b0}}, reg_a} - {{DATA_W{1'b0}}, reg_b};
`endif
      end
      OP_MUL: begin
        fin     = mul_last;
        fin_val = mul_product;
      end
      OP_MOD3: begin
        fin     = (mod_work < THREE);
        fin_val = {{DATA_W{1'b0}}, mod_work};
      end
      default: begin
        fin     = 1'b1;
        fin_val = result;
      end
    endcase
  end

  // FSM next state: IDLE -> CALC on trigger, CALC -> DONE on final step.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (trigger) state_next = ST_CALC; else state_next = ST_IDLE;
      ST_CALC: if (fin) state_next = ST_DONE; else state_next = ST_CALC;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, operands, op latch, MOD3 work register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ctrl_q   <= 4'b0000;
      op       <= 4'b0000;
      reg_a    <= {DATA_W{1'b0}};
      reg_b    <= {DATA_W{1'b0}};
      mod_work <= {DATA_W{1'b0}};
      result   <= {(2*DATA_W){1'b0}};
      done     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      ctrl_q <= control;
      state  <= state_next;
      reg_a  <= a_next;
      reg_b  <= b_next;
      busy   <= (state_next == ST_CALC);
      done   <= (state_next == ST_DONE);
      if (trigger) begin
        op       <= control;
        mod_work <= a_next;
      end else if ((state == ST_CALC) && (op == OP_MOD3) && !fin) begin
        mod_work <= mod_work - THREE;
      end
      if ((state == ST_CALC) && fin) begin
        result <= fin_val;
      end
      if (trigger) begin
        err <= 1'b0;
      end else if (illegal) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning operand width in bits.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port control, input, 4, one-hot op select: 0001 ADD, 0010 SUB, 0100 MUL, 1000 MOD3, 0000 none.
REQ-005 The block SHALL have port operand_in, input, DATA_W, operand data bus.
REQ-006 The block SHALL have ports load_a and load_b, input, 1 each, operand A/B capture strobes.
REQ-007 The block SHALL have port result, output, 2*DATA_W, last completed result.
REQ-008 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 The block SHALL have ports busy and err, output, 1 each: busy means an operation is in progress; err means an illegal control code was seen.

Function
REQ-010 The block SHALL register control every cycle into ctrl_q.
REQ-011 When busy=0, load_a SHALL capture operand_in into reg A and load_b SHALL capture it into reg B; if both are high in the same cycle, both SHALL capture the same value.
REQ-012 When busy=0, a trigger SHALL occur on the edge where control is one-hot and either control!=ctrl_q or load_a/load_b is high; a simultaneous load and control change SHALL form one trigger that uses the newly loaded operands.
REQ-013 The FSM SHALL have states IDLE, CALC and DONE: IDLE->CALC on trigger; CALC->DONE after the final step; DONE->IDLE unconditionally.
REQ-014 The op code and operands SHALL be latched at the trigger; changes to control, loads or other triggers while busy=1 SHALL be ignored.
REQ-015 busy SHALL be 1 in CALC only; done SHALL be 1 in DONE only; result SHALL update on the CALC->DONE edge and hold otherwise.
REQ-016 Step counts SHALL be: ADD 1, SUB 1, MUL DATA_W, MOD3 floor(A/3)+1; done is therefore visible in the cycle after edge T+steps, where T is the trigger edge.
REQ-017 ADD SHALL yield A+B zero-extended to 2*DATA_W.
REQ-018 SUB SHALL yield A-B in 2*DATA_W two's complement with wrap-around (see REQ-025 for the alternative).
REQ-019 MUL SHALL be an unsigned shift-add, one partial product per step, giving the exact 2*DATA_W product.
REQ-020 MOD3 SHALL subtract 3 from A per step while A>=3, with the final step detecting A<3; result SHALL be A mod 3, zero-extended.
REQ-021 A nonzero, non-one-hot control code sampled while busy=0 SHALL set err with no operation started; err SHALL stay set until the next valid trigger clears it.
REQ-022 control=0000 SHALL never trigger.

Reset
REQ-023 Reset SHALL force IDLE and clear A, B, ctrl_q, result, done, busy and err to 0 immediately, including mid-operation, and the aborted operation SHALL produce no done pulse.
REQ-024 After reset release, control values already one-hot SHALL trigger on the first edge, because ctrl_q=0.

Configuration
REQ-025 With macro ALU_SUB_SAT_EN defined, SUB SHALL clamp to 0 when B>A; without it, SUB SHALL wrap per REQ-018.

Structure
REQ-026 Package alu_pkg SHALL hold the op one-hot constants, the FSM state enum (logic[1:0]) and the default DATA_W; the upstream button controller SHALL import the same constants.
REQ-027 The multiplier SHALL be the sub-module alu_mul_seq (start, A, B -> product, last_step); all other logic SHALL be inline.

Verification
REQ-028 Load A=200, B=100, then control=0001 -> after 1 step, done=1 and result=300; busy is high for 1 cycle.
REQ-029 A=5, B=9, control=0010 -> result=16'hFFFC without the macro, and result=0 with ALU_SUB_SAT_EN.
REQ-030 A=255, B=255, control=0100 -> busy is high for 8 cycles, then result=65025 with a single done pulse; a control change to 0001 while busy is ignored.
REQ-031 A=200, control=1000 -> 67 steps, result=2; then A=0 with load_a held and control unchanged -> retrigger, 1 step, result=0.
REQ-032 control=0011 -> err=1, busy stays 0, no done; then control=0001 -> err clears and ADD runs.
REQ-033 Reset asserted at step 4 of MUL -> all outputs are 0 in the same cycle, no done pulse; after release, control held at 0100 retriggers.
